// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package if_fetch_pkg;

  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_inst_buf.sv
// Load-enabled instruction holding register, resets to the NOP encoding.
module if_inst_buf
  import if_fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RST_VAL = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] d,
  output logic [INST_W-1:0] q
);

  logic [INST_W-1:0] data_q;
  logic [INST_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= RST_VAL;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word requests, presents instructions to IF/ID,
// buffers across downstream stalls and drains outstanding requests on redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0]       RESET_PC = RESET_PC_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [31:0]       IF_pc,
  output logic [INST_W-1:0] IF_inst,
  output logic              if_stall_req
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       drain_addr_q, drain_addr_d;
  logic [31:0]       pc_inc;
  logic [31:0]       br_pc;
  logic              buf_load;
  logic [INST_W-1:0] buf_inst;
  logic              fetch_hit;
  logic              presented;

  assign pc_inc = pc_q + 32'd4;
  assign br_pc  = br_target & ~32'd3;

  if_inst_buf #(
    .RST_VAL (NOP_INST)
  ) u_inst_buf (
    .clk  (clk),
    .rst  (rst),
    .load (buf_load),
    .d    (imem_rdata),
    .q    (buf_inst)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_load     = 1'b0;
    case (state_q)
      FETCH: begin
        if (br_taken) begin
          pc_d = br_pc;
          // Redirect with the request still open: remember its address so it
          // stays on the bus until the stale response arrives.
          if (!imem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (stall) begin
            state_d  = HOLD;
            buf_load = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_d    = br_pc;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (br_taken) pc_d = br_pc;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Outputs are gated by rst directly so they are quiet while reset is held.
  always_comb begin
    fetch_hit    = (state_q == FETCH) && imem_ack;
    presented    = !rst && (fetch_hit || (state_q == HOLD));
    imem_req     = !rst && (state_q != HOLD);
    imem_addr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
    IF_pc        = pc_q;
    if_stall_req = !presented;
    IF_inst      = NOP_INST;
    if (presented) IF_inst = (state_q == HOLD) ? buf_inst : imem_rdata;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed cycles push expected request addresses
// and presented {pc,inst} pairs; a negedge monitor pops and compares them.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        if_stall_req;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [31:0] addr_exp_q[$];
  logic [63:0] pres_exp_q[$];

  if_fetch #(
    .RESET_PC (32'h8000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .IF_pc        (IF_pc),
    .IF_inst      (IF_inst),
    .if_stall_req (if_stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every requesting cycle and every presenting cycle consumes one entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req) begin
        if (addr_exp_q.size() == 0) chk("unexpected_req", {32'd0, imem_addr}, 64'hDEAD);
        else chk("imem_addr", {32'd0, imem_addr}, {32'd0, addr_exp_q.pop_front()});
      end
      if (!if_stall_req) begin
        if (pres_exp_q.size() == 0) chk("unexpected_present", {IF_pc, IF_inst}, 64'hDEAD);
        else chk("present_pc_inst", {IF_pc, IF_inst}, pres_exp_q.pop_front());
      end
    end
  end

  // Apply one cycle of inputs and queue what the DUT should show in that cycle.
  task automatic drive(input logic s, input logic a, input logic [31:0] rd,
                       input logic b, input logic [31:0] tgt,
                       input logic er, input logic [31:0] ea,
                       input logic ep, input logic [31:0] epc, input logic [31:0] einst);
    stall = s; imem_ack = a; imem_rdata = rd; br_taken = b; br_target = tgt;
    if (er) addr_exp_q.push_back(ea);
    if (ep) pres_exp_q.push_back({epc, einst});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req",   {63'd0, imem_req}, 64'd0);
    chk("rst_pc",    {32'd0, IF_pc}, {32'd0, 32'h8000_0000});
    chk("rst_inst",  {32'd0, IF_inst}, 64'd0);
    chk("rst_stall", {63'd0, if_stall_req}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back single-cycle fetches
    drive(0, 1, 32'hA000_0000, 0, 0, 1, 32'h8000_0000, 1, 32'h8000_0000, 32'hA000_0000); step();
    drive(0, 1, 32'hA000_0001, 0, 0, 1, 32'h8000_0004, 1, 32'h8000_0004, 32'hA000_0001); step();
    drive(0, 1, 32'hA000_0002, 0, 0, 1, 32'h8000_0008, 1, 32'h8000_0008, 32'hA000_0002); step();

    // Waiting fetch, then stall for three cycles into HOLD
    drive(0, 0, 32'h0, 0, 0, 1, 32'h8000_000C, 0, 0, 0); #1;
    chk("wait_stall_req", {63'd0, if_stall_req}, 64'd1);
    chk("wait_nop",       {32'd0, IF_inst}, 64'd0);
    step();
    drive(1, 1, 32'hA000_0003, 0, 0, 1, 32'h8000_000C, 1, 32'h8000_000C, 32'hA000_0003); step();
    drive(1, 0, 32'h0, 0, 0, 0, 0, 1, 32'h8000_000C, 32'hA000_0003); #1;
    chk("hold_req", {63'd0, imem_req}, 64'd0);
    step();
    drive(1, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, 1, 32'h8000_000C, 32'hA000_0003); step();
    drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h8000_000C, 32'hA000_0003); step();
    drive(0, 1, 32'hA000_0004, 0, 0, 1, 32'h8000_0010, 1, 32'h8000_0010, 32'hA000_0004); step();

    // Redirect to an unaligned target while the request is still open
    drive(0, 0, 32'h0, 1, 32'h8000_1002, 1, 32'h8000_0014, 0, 0, 0); step();
    drive(0, 0, 32'h0, 0, 0, 1, 32'h8000_0014, 0, 0, 0); #1;
    chk("drain_pc", {32'd0, IF_pc}, {32'd0, 32'h8000_1000});
    step();
    drive(0, 1, 32'hBAD1_BAD1, 0, 0, 1, 32'h8000_0014, 0, 0, 0); #1;
    chk("drain_ack_nop", {32'd0, IF_inst}, 64'd0);
    step();
    drive(0, 1, 32'hA000_0005, 0, 0, 1, 32'h8000_1000, 1, 32'h8000_1000, 32'hA000_0005); step();

    // Redirect together with stall while holding
    drive(1, 1, 32'hA000_0006, 0, 0, 1, 32'h8000_1004, 1, 32'h8000_1004, 32'hA000_0006); step();
    drive(1, 0, 32'h0, 1, 32'h8000_3000, 0, 0, 1, 32'h8000_1004, 32'hA000_0006); step();
    drive(1, 0, 32'h0, 0, 0, 1, 32'h8000_3000, 0, 0, 0); #1;
    chk("buf_gone", {32'd0, IF_inst}, 64'd0);
    step();
    drive(0, 1, 32'hA000_0007, 0, 0, 1, 32'h8000_3000, 1, 32'h8000_3000, 32'hA000_0007); step();

    // Redirect on an acked cycle to the top word, then wrap
    drive(0, 1, 32'hA000_0008, 1, 32'hFFFF_FFFF, 1, 32'h8000_3004, 1, 32'h8000_3004, 32'hA000_0008); step();
    drive(0, 1, 32'hA000_0009, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hA000_0009); step();
    drive(0, 1, 32'hA000_000A, 0, 0, 1, 32'h0000_0000, 1, 32'h0000_0000, 32'hA000_000A); step();

    // Two redirects while draining: the later target wins
    drive(0, 0, 32'h0, 1, 32'h9000_0000, 1, 32'h0000_0004, 0, 0, 0); step();
    drive(0, 0, 32'h0, 1, 32'h8000_2007, 1, 32'h0000_0004, 0, 0, 0); step();
    drive(0, 1, 32'hBAD2_BAD2, 0, 0, 1, 32'h0000_0004, 0, 0, 0); step();
    drive(0, 1, 32'hA000_000B, 0, 0, 1, 32'h8000_2004, 1, 32'h8000_2004, 32'hA000_000B); step();

    // Reset in the middle of an unanswered request
    drive(0, 0, 32'h0, 0, 0, 1, 32'h8000_2008, 0, 0, 0); step();
    rst = 1'b1; #1;
    chk("mid_rst_req",   {63'd0, imem_req}, 64'd0);
    chk("mid_rst_pc",    {32'd0, IF_pc}, {32'd0, 32'h8000_0000});
    chk("mid_rst_stall", {63'd0, if_stall_req}, 64'd1);
    step();
    rst = 1'b0;
    drive(0, 1, 32'hA000_000C, 0, 0, 1, 32'h8000_0000, 1, 32'h8000_0000, 32'hA000_000C); step();

    rst = 1'b1; imem_ack = 1'b0;
    step(); step();
    chk("addr_queue_left", {32'd0, addr_exp_q.size()}, 64'd0);
    chk("pres_queue_left", {32'd0, pres_exp_q.size()}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
